dcache_axi_wb_master: RTL

// Downstream of the dcache write-back FIFO: takes one cache line at a time from the FIFO head and

---
 rtl/core_config.sv | 9 +
 rtl/dcache_axi_wb_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/core_config.sv
// Shared core configuration: cache geometry, AXI encodings and the write-back master state type.
package core_config;
  localparam int DCACHELINE_WIDTH = 128;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, BURST, RESP} wb_state_t;
endpackage

// File: rtl/dcache_axi_wb_master.sv
// Drains one dcache write-back line per transaction as a single AXI4 INCR write burst.
// The line is latched on acceptance so the FIFO head may change underneath without affecting the burst.
module dcache_axi_wb_master
  import core_config::*;
#(
  parameter int          LINE_W = DCACHELINE_WIDTH,
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 32,
  parameter logic [3:0]  AXI_ID = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen_i,
  input  logic [LINE_W-1:0]   wdata_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  output logic                req_accept_o,
  output logic                bvalid_o,
  output logic                bresp_err_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [3:0]          awid_o,
  output logic [7:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  input  logic                bvalid_i,
  output logic                bready_o,
  input  logic [1:0]          bresp_i
);

  localparam int                BEATS     = LINE_W / DATA_W;
  localparam int                CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_W / 8 - 1);

  wb_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                aw_done_q, aw_done_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                accept_q, accept_d;
  logic                bpulse_q, bpulse_d;
  logic                err_q, err_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;

  logic aw_hs, w_hs, last_hs;

  assign aw_hs   = awvalid_q & awready_i;
  assign w_hs    = wvalid_q & wready_i;
  assign last_hs = w_hs && (cnt_q == LAST_BEAT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    line_d    = line_q;
    addr_d    = addr_q;
    accept_d  = 1'b0;
    bpulse_d  = 1'b0;
    err_d     = err_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    unique case (state_q)
      IDLE: begin
        // The done-pulse cycle still shows the old FIFO head, so it must not be re-accepted.
        if (wen_i && !bpulse_q) begin
          state_d   = BURST;
          line_d    = wdata_i;
          addr_d    = awaddr_i & ~LINE_MASK;
          accept_d  = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          cnt_d     = '0;
          aw_done_d = 1'b0;
        end
      end
      BURST: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          if (last_hs) wvalid_d = 1'b0;
          else         cnt_d    = cnt_q + CNT_W'(1);
        end
        // wvalid_q low inside BURST means every beat has already been taken.
        if ((aw_done_q || aw_hs) && (!wvalid_q || last_hs)) begin
          state_d  = RESP;
          bready_d = 1'b1;
          cnt_d    = '0;
        end
      end
      RESP: begin
        if (bvalid_i && bready_q) begin
          state_d   = IDLE;
          bready_d  = 1'b0;
          bpulse_d  = 1'b1;
          aw_done_d = 1'b0;
          if (bresp_i != AXI_RESP_OKAY) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      line_q    <= '0;
      addr_q    <= '0;
      accept_q  <= 1'b0;
      bpulse_q  <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      line_q    <= line_d;
      addr_q    <= addr_d;
      accept_q  <= accept_d;
      bpulse_q  <= bpulse_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  assign req_accept_o = accept_q;
  assign bvalid_o     = bpulse_q;
  assign bresp_err_o  = err_q;
  assign awvalid_o    = awvalid_q;
  assign awaddr_o     = addr_q;
  assign awid_o       = AXI_ID;
  assign awlen_o      = 8'(BEATS - 1);
  assign awsize_o     = 3'($clog2(DATA_W / 8));
  assign awburst_o    = AXI_BURST_INCR;
  assign wvalid_o     = wvalid_q;
  assign wdata_o      = line_q[DATA_W*int'(cnt_q) +: DATA_W];
  assign wstrb_o      = '1;
  assign wlast_o      = wvalid_q && (cnt_q == LAST_BEAT);
  assign bready_o     = bready_q;

endmodule
